// File: rtl/matrix_ops_pkg.sv
// Shared definitions for the matrix-sum accelerator driver: push-burst
// framing constants, sequencer state encoding and a log2 helper.
package matrix_ops_pkg;

  // Each push burst starts with one start word and one count word,
  // followed by N A-elements and N B-elements: 2N+2 words in total.
  localparam int START_WORDS = 1;
  localparam int COUNT_WORDS = 1;
  localparam int HDR_WORDS   = START_WORDS + COUNT_WORDS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    WAIT_DEV = 3'd3,
    BURST    = 3'd4,
    WAIT_RES = 3'd5,
    POP      = 3'd6,
    DRAIN    = 3'd7
  } state_t;

  // Ceiling log2, never below 1 so it can size an address bus.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/matrices_sum_driver_sync_fifo2.sv
// Two-entry output FIFO holding popped accelerator results until the
// downstream consumer takes them. Head is presented combinationally.
module sync_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en && (count_reg != 2'd0);
  // A write while full is only safe if the head leaves on the same edge.
  assign do_wr = wr_en && ((count_reg != 2'd2) || do_rd);

  // Storage, pointers and occupancy; cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_rd) rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data   = mem_reg[rd_ptr_reg];
  assign empty     = (count_reg == 2'd0);
  assign occupancy = count_reg;

endmodule

// File: rtl/matrices_sum_driver.sv
// Initiator-side sequencer for the matrix-sum accelerator: buffers a job
// (count, A, B) from an upstream stream, replays it as one gap-free push
// burst, then pops the results into a small FIFO feeding a downstream stream.
module matrices_sum_driver
  import matrix_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ELEMS  = 128,
  parameter int REGS_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_dev_push,
  output logic [DATA_WIDTH-1:0] o_dev_data,
  output logic                  o_dev_pop,
  input  logic [DATA_WIDTH-1:0] i_dev_data,
  input  logic                  i_dev_ready,
  input  logic                  i_dev_res_avail,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int AW = clogb2(MAX_ELEMS);
  localparam logic [REGS_WIDTH-1:0] HDR   = REGS_WIDTH'(HDR_WORDS);
  localparam logic [REGS_WIDTH-1:0] ONE_R = REGS_WIDTH'(1);
  localparam logic [AW-1:0]         ONE_A = AW'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_N = DATA_WIDTH'(MAX_ELEMS);

  state_t                  state;
  logic                    s_ready_reg;
  logic                    err_reg;
  logic                    push_reg;
  logic                    pop_reg;
  logic                    pop_d_reg;
  logic [DATA_WIDTH-1:0]   dev_data_reg;
  logic [REGS_WIDTH-1:0]   count_reg;
  logic [REGS_WIDTH-1:0]   burst_reg;
  logic [REGS_WIDTH-1:0]   issued_reg;
  logic [REGS_WIDTH-1:0]   captured_reg;
  logic [AW-1:0]           idx_reg;

  logic [DATA_WIDTH-1:0]   a_mem [MAX_ELEMS];
  logic [DATA_WIDTH-1:0]   b_mem [MAX_ELEMS];

  logic                    accept;
  logic                    count_ok;
  logic                    idx_last;
  logic                    burst_last;
  logic                    pop_ok;
  logic                    deq;
  logic                    fifo_empty;
  logic [1:0]              fifo_occ;
  logic [2:0]              occ_next;
  logic [REGS_WIDTH-1:0]   burst_next;
  logic [REGS_WIDTH-1:0]   issued_total;
  logic [REGS_WIDTH-1:0]   captured_total;
  logic [DATA_WIDTH-1:0]   burst_word;
  logic [DATA_WIDTH-1:0]   fifo_head;

  assign accept     = i_s_valid && s_ready_reg;
  assign count_ok   = (i_s_data != '0) && (i_s_data <= MAX_N);
  assign idx_last   = ({{(REGS_WIDTH-AW){1'b0}}, idx_reg} == (count_reg - ONE_R));
  assign burst_last = (burst_reg == ((count_reg << 1) + HDR - ONE_R));
  assign burst_next = burst_reg + ONE_R;
  assign deq        = !fifo_empty && i_m_ready;

  // Occupancy the FIFO will have next cycle; a pop issued now is still in
  // flight then, so both must leave room for its captured word.
  assign occ_next       = {1'b0, fifo_occ} + {2'b00, pop_d_reg} - {2'b00, deq};
  assign pop_ok         = (occ_next + {2'b00, pop_reg}) < 3'd2;
  assign issued_total   = issued_reg + REGS_WIDTH'(pop_reg);
  assign captured_total = captured_reg + REGS_WIDTH'(pop_d_reg);

  // Word to drive on the next burst cycle: header, then A, then B.
  always_comb begin
    burst_word = DATA_WIDTH'(count_reg);
    if (burst_next < HDR) begin
      burst_word = DATA_WIDTH'(count_reg);
    end else if (burst_next < (HDR + count_reg)) begin
      burst_word = a_mem[AW'(burst_next - HDR)];
    end else begin
      burst_word = b_mem[AW'(burst_next - HDR - count_reg)];
    end
  end

  // Operand buffers: plain register arrays filled during the load states.
  always_ff @(posedge i_clk) begin
    if (state == LOAD_A && accept) a_mem[idx_reg] <= i_s_data;
    if (state == LOAD_B && accept) b_mem[idx_reg] <= i_s_data;
  end

  // Job sequencer with registered handshake and accelerator strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      s_ready_reg  <= 1'b0;
      err_reg      <= 1'b0;
      push_reg     <= 1'b0;
      pop_reg      <= 1'b0;
      pop_d_reg    <= 1'b0;
      dev_data_reg <= '0;
      count_reg    <= '0;
      burst_reg    <= '0;
      issued_reg   <= '0;
      captured_reg <= '0;
      idx_reg      <= '0;
    end else begin
      err_reg   <= 1'b0;
      pop_d_reg <= pop_reg;
      case (state)
        IDLE: begin
          s_ready_reg <= 1'b1;
          if (accept) begin
            if (count_ok) begin
              count_reg <= REGS_WIDTH'(i_s_data);
              idx_reg   <= '0;
              state     <= LOAD_A;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (idx_last) begin
              idx_reg <= '0;
              state   <= LOAD_B;
            end else begin
              idx_reg <= idx_reg + ONE_A;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (idx_last) begin
              idx_reg     <= '0;
              s_ready_reg <= 1'b0;
              state       <= WAIT_DEV;
            end else begin
              idx_reg <= idx_reg + ONE_A;
            end
          end
        end
        WAIT_DEV: begin
          if (i_dev_ready && !i_dev_res_avail) begin
            push_reg     <= 1'b1;
            dev_data_reg <= DATA_WIDTH'(count_reg);
            burst_reg    <= '0;
            state        <= BURST;
          end
        end
        BURST: begin
          if (burst_last) begin
            push_reg     <= 1'b0;
            dev_data_reg <= '0;
            state        <= WAIT_RES;
          end else begin
            burst_reg    <= burst_next;
            dev_data_reg <= burst_word;
          end
        end
        WAIT_RES: begin
          if (i_dev_res_avail) begin
            issued_reg   <= '0;
            captured_reg <= '0;
            pop_reg      <= 1'b0;
            state        <= POP;
          end
        end
        POP: begin
          issued_reg   <= issued_total;
          captured_reg <= captured_total;
          if (issued_total == count_reg && captured_total == count_reg) begin
            pop_reg <= 1'b0;
            state   <= DRAIN;
          end else begin
            pop_reg <= (issued_total < count_reg) && pop_ok;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            s_ready_reg <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Popped words land in the FIFO one cycle after their pop strobe.
  sync_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .wr_en    (pop_d_reg),
    .wr_data  (i_dev_data),
    .rd_en    (deq),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .occupancy(fifo_occ)
  );

  assign o_s_ready  = s_ready_reg;
  assign o_dev_push = push_reg;
  assign o_dev_data = dev_data_reg;
  assign o_dev_pop  = pop_reg;
  assign o_m_valid  = !fifo_empty;
  assign o_m_data   = fifo_head;
  assign o_busy     = (state != IDLE);
  assign o_err      = err_reg;

endmodule

// File: tb/tb_matrices_sum_driver.sv
// Scoreboard bench for matrices_sum_driver with a behavioural accelerator.
module tb_matrices_sum_driver;

  localparam int ME = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        s_ready;
  logic        dev_push;
  logic [15:0] dev_data_out;
  logic        dev_pop;
  logic [15:0] dev_data_in = 16'd0;
  logic        dev_ready = 1'b1;
  logic        dev_res_avail = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  matrices_sum_driver #(
    .DATA_WIDTH(16),
    .MAX_ELEMS (ME),
    .REGS_WIDTH(16)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_s_valid      (s_valid),
    .i_s_data       (s_data),
    .o_s_ready      (s_ready),
    .o_dev_push     (dev_push),
    .o_dev_data     (dev_data_out),
    .o_dev_pop      (dev_pop),
    .i_dev_data     (dev_data_in),
    .i_dev_ready    (dev_ready),
    .i_dev_res_avail(dev_res_avail),
    .o_m_valid      (m_valid),
    .o_m_data       (m_data),
    .i_m_ready      (m_ready),
    .o_busy         (busy),
    .o_err          (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural accelerator: collects a push burst, sums, serves pops.
  logic [15:0] acc_buf [264];
  int          acc_n = 0;
  logic [15:0] res_mem [256];
  int          res_wr = 0;
  int          res_rd = 0;

  always @(posedge clk) begin
    int n;
    if (dev_push) begin
      acc_buf[acc_n] = dev_data_out;
      acc_n++;
      if (acc_n >= 2) begin
        n = int'(acc_buf[1]);
        if (n >= 1 && n <= ME && acc_n == 2 + 2 * n) begin
          for (int k = 0; k < n; k++) begin
            res_mem[res_wr] = acc_buf[2 + k] + acc_buf[2 + n + k];
            res_wr++;
          end
          acc_n = 0;
        end
      end
      if (acc_n >= 264) acc_n = 0;
    end else begin
      acc_n = 0;
    end
    if (dev_pop && res_rd < res_wr) begin
      dev_data_in <= res_mem[res_rd];
      res_rd++;
    end
    dev_ready     <= (acc_n == 0);
    dev_res_avail <= (res_rd < res_wr);
  end

  // Scoreboard queues filled by stimulus.
  logic [15:0] exp_push [$];
  logic [15:0] exp_res [$];
  int          exp_len [$];

  int  run_len = 0;
  int  tb_occ = 0;
  bit  pop_prev = 1'b0;
  int  cyc = 0;
  bit  pop_seen = 1'b0;
  bit  val_seen = 1'b0;
  int  pop_cyc = 0;
  int  err_seen = 0;
  int  xfers = 0;
  bit  bp_mode = 1'b0;

  // Monitor: samples mid-cycle and compares against the queues.
  always @(negedge clk) begin
    int e;
    logic [15:0] w;
    cyc++;
    if (!rst_n) begin
      exp_push.delete();
      exp_len.delete();
      run_len  = 0;
      tb_occ   = 0;
      pop_prev = 1'b0;
      pop_seen = 1'b0;
      val_seen = 1'b0;
    end else begin
      if (dev_push || dev_pop)
        chk(!(dev_push && dev_pop), "push_pop_exclusive", {dev_push, dev_pop}, 0);
      if (dev_push) begin
        chk(exp_push.size() > 0, "push_expected", dev_data_out, 0);
        if (exp_push.size() > 0) begin
          w = exp_push.pop_front();
          chk(dev_data_out == w, "push_data", dev_data_out, w);
        end
        run_len++;
      end else if (run_len > 0) begin
        chk(exp_len.size() > 0, "burst_expected", run_len, 0);
        if (exp_len.size() > 0) begin
          e = exp_len.pop_front();
          chk(run_len == e, "burst_len", run_len, e);
          $display("burst pushed=%0d expected=%0d", run_len, e);
        end
        run_len = 0;
      end
      if (dev_pop) begin
        chk(tb_occ + int'(pop_prev) < 2, "pop_throttle", tb_occ + int'(pop_prev), 1);
        if (!pop_seen) begin
          pop_seen = 1'b1;
          pop_cyc  = cyc;
        end
      end
      if (m_valid && pop_seen && !val_seen) begin
        val_seen = 1'b1;
        chk(cyc - pop_cyc == 2, "first_result_latency", cyc - pop_cyc, 2);
      end
      if (m_valid && m_ready) begin
        chk(busy, "busy_during_xfer", busy, 1);
        chk(exp_res.size() > 0, "result_expected", m_data, 0);
        if (exp_res.size() > 0) begin
          w = exp_res.pop_front();
          chk(m_data == w, "result_data", m_data, w);
          $display("xfer %0d result=%h expected=%h", xfers, m_data, w);
          xfers++;
        end
      end
      if (err) err_seen++;
      tb_occ   = tb_occ + int'(pop_prev) - ((m_valid && m_ready) ? 1 : 0);
      pop_prev = dev_pop;
      if (!busy) begin
        pop_seen = 1'b0;
        val_seen = 1'b0;
      end
    end
  end

  // Downstream ready: always high, or 1 cycle high / 3 low under back-pressure.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_ready = (ph == 0);
        ph = (ph + 1) % 4;
      end else begin
        m_ready = 1'b1;
        ph = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic [15:0] vr [4];

  task automatic send_word(input logic [15:0] w, input int gap);
    int t;
    s_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 1000, "upstream_accept_timeout", t, 1000);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 16'd0;
  endtask

  task automatic send_job(input int n, input int gmax, input bit with_res);
    exp_push.push_back(16'(n));
    exp_push.push_back(16'(n));
    for (int k = 0; k < n; k++) exp_push.push_back(va[k]);
    for (int k = 0; k < n; k++) exp_push.push_back(vb[k]);
    exp_len.push_back(2 * n + 2);
    if (with_res)
      for (int k = 0; k < n; k++) exp_res.push_back(vr[k]);
    send_word(16'(n), 0);
    for (int k = 0; k < n; k++) send_word(va[k], int'($urandom_range(0, gmax)));
    for (int k = 0; k < n; k++) send_word(vb[k], int'($urandom_range(0, gmax)));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_res.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 5000, "job_timeout", t, 5000);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    logic [37:0] v;
    v = {s_ready, dev_push, dev_data_out, dev_pop, m_valid, m_data, busy, err};
    chk(v == 38'd0, name, v, 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst_n = 1'b1;
    #1;
    chk(!s_ready, "ready_before_first_clock", s_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk(s_ready, "ready_after_reset", s_ready, 1);
    chk(!busy, "idle_after_reset", busy, 0);
    @(posedge clk);
    #1;

    // Basic job
    va = '{16'd1, 16'd2, 16'd3, 16'd0};
    vb = '{16'd10, 16'd20, 16'd30, 16'd0};
    vr = '{16'd11, 16'd22, 16'd33, 16'd0};
    send_job(3, 0, 1'b1);
    wait_done();

    // Signed wrap
    va = '{16'h7FFF, 16'hFFFF, 16'd0, 16'd0};
    vb = '{16'h0001, 16'hFFFF, 16'd0, 16'd0};
    vr = '{16'h8000, 16'hFFFE, 16'd0, 16'd0};
    send_job(2, 0, 1'b1);
    wait_done();

    // Downstream back-pressure
    bp_mode = 1'b1;
    va = '{16'd100, 16'd200, 16'd300, 16'd400};
    vb = '{16'd1, 16'd2, 16'd3, 16'd4};
    vr = '{16'd101, 16'd202, 16'd303, 16'd404};
    send_job(4, 0, 1'b1);
    wait_done();
    bp_mode = 1'b0;

    // Upstream gaps
    va = '{16'd5, 16'd6, 16'd7, 16'd0};
    vb = '{16'd1000, 16'd2000, 16'd3000, 16'd0};
    vr = '{16'd1005, 16'd2006, 16'd3007, 16'd0};
    send_job(3, 3, 1'b1);
    wait_done();

    // Bad counts then a minimal job
    send_word(16'd0, 0);
    chk(err, "err_pulse_n0", err, 1);
    @(posedge clk);
    #1;
    chk(!err, "err_one_cycle_n0", err, 0);
    chk(!busy, "idle_after_n0", busy, 0);
    send_word(16'(ME + 1), 0);
    chk(err, "err_pulse_nmax1", err, 1);
    @(posedge clk);
    #1;
    chk(!err, "err_one_cycle_nmax1", err, 0);
    chk(!busy, "idle_after_nmax1", busy, 0);
    va = '{16'd5, 16'd0, 16'd0, 16'd0};
    vb = '{16'd7, 16'd0, 16'd0, 16'd0};
    vr = '{16'd12, 16'd0, 16'd0, 16'd0};
    send_job(1, 0, 1'b1);
    wait_done();
    chk(err_seen == 2, "err_count", err_seen, 2);

    // Reset during burst cycle 3
    va = '{16'd1, 16'd1, 16'd1, 16'd0};
    vb = '{16'd2, 16'd2, 16'd2, 16'd0};
    send_job(3, 0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!dev_push && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 1000, "burst_start_timeout", t, 1000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_burst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(s_ready, "ready_after_mid_reset", s_ready, 1);
    chk(!busy, "idle_after_mid_reset", busy, 0);
    @(posedge clk);
    #1;

    // Recovery job
    va = '{16'd3, 16'd4, 16'd0, 16'd0};
    vb = '{16'd4, 16'd5, 16'd0, 16'd0};
    vr = '{16'd7, 16'd9, 16'd0, 16'd0};
    send_job(2, 0, 1'b1);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk(exp_res.size() == 0, "results_leftover", exp_res.size(), 0);
    chk(exp_push.size() == 0, "pushes_leftover", exp_push.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrices_sum_driver.md
Name: matrices_sum_driver

Overview:
- Initiator-side sequencer for the integer matrix-sum accelerator's push/pop port.
- Accepts a job from an upstream valid/ready stream: count word N, then N A-elements, then N B-elements. Buffers the whole job locally.
- Replays the job as the gap-free push burst the accelerator requires, then pops the N results and emits them on a downstream valid/ready stream.
- Sits between a host/DMA stream and one accelerator instance.

Parameters:
- DATA_WIDTH, 16, width of every data word (elements and count).
- MAX_ELEMS, 128, maximum elements per matrix; equals the accelerator's operand half-buffer.
- REGS_WIDTH, 16, width of the count and element counters.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_s_valid  in  1  upstream word valid.
- i_s_data  in  DATA_WIDTH  upstream word (count, then A elements, then B elements).
- o_s_ready  out  1  upstream word accepted when valid and ready are both high.
- o_dev_push  out  1  push strobe to accelerator.
- o_dev_data  out  DATA_WIDTH  push data to accelerator.
- o_dev_pop  out  1  pop strobe to accelerator.
- i_dev_data  in  DATA_WIDTH  accelerator result word.
- i_dev_ready  in  1  accelerator idle.
- i_dev_res_avail  in  1  accelerator holds unread results.
- o_m_valid  out  1  downstream result valid.
- o_m_data  out  DATA_WIDTH  downstream result (signed two's complement).
- i_m_ready  in  1  downstream accept.
- o_busy  out  1  job in progress (any state other than IDLE).
- o_err  out  1  one-cycle pulse when a count word is rejected.

Behaviour:
- Reset: every output is 0 (o_s_ready, o_dev_push, o_dev_data, o_dev_pop, o_m_valid, o_m_data, o_busy, o_err); FSM enters IDLE; counters and output FIFO are cleared.
  - Reset mid-burst simply drops push; the accelerator then aborts on its own.
- IDLE: o_s_ready=1. An accepted word is the count N.
  - 1<=N<=MAX_ELEMS: latch N, go to LOAD_A.
  - Otherwise: pulse o_err for one cycle and stay in IDLE. Only the count word is consumed.
- LOAD_A: o_s_ready=1. Store each accepted word in a_mem[k], k=0..N-1. After word N-1, go to LOAD_B.
- LOAD_B: same as LOAD_A, into b_mem[k]. After word N-1, o_s_ready=0 and go to WAIT_DEV.
- Upstream gaps (i_s_valid=0) are legal in all load states; the FSM holds.
- WAIT_DEV: stay until i_dev_ready=1 and i_dev_res_avail=0, then go to BURST.
- BURST: o_dev_push=1 on exactly 2N+2 consecutive cycles, never deasserted mid-burst. Data per burst cycle c:
  - c=0: start word, o_dev_data=N.
  - c=1: count word, N.
  - c=2..N+1: a_mem[c-2].
  - c=N+2..2N+1: b_mem[c-N-2].
  - The cycle after the last push: o_dev_push=0, go to WAIT_RES.
- WAIT_RES: wait for i_dev_res_avail=1, then go to POP.
- POP:
  - o_dev_pop is asserted only while (output FIFO occupancy + pops in flight) < 2.
  - i_dev_data is captured into the FIFO on the cycle after each pop.
  - Back-to-back pops are allowed.
  - After N pops have been issued and N words captured, go to DRAIN.
- DRAIN: when the FIFO is empty, return to IDLE.
- Output FIFO: 2 entries; o_m_valid = not empty; o_m_data = head.
  - Simultaneous capture and dequeue at occupancy 2 cannot occur because the pop throttle prevents it.
- Rules common to all states:
  - o_dev_pop and o_dev_push are never high in the same cycle.
  - o_dev_push is high only in BURST; o_dev_pop only in POP.
  - No arithmetic is done here: results pass through bit-exact, so signed overflow wraps as in the accelerator.
- Latency with no back-pressure: first o_m_valid is 2 cycles after the first pop.

Decomposition:
- Shared package matrix_ops_pkg holds:
  - the accelerator protocol constants: start-word count 1 and count-word count 1, giving burst length 2N+2;
  - the FSM state encoding: IDLE, LOAD_A, LOAD_B, WAIT_DEV, BURST, WAIT_RES, POP, DRAIN;
  - the clogb2 function.
- One sub-module, sync_fifo2: 2-entry output FIFO with occupancy output.
- a_mem and b_mem are plain register arrays inside the top module.

Test Plan:
- Basic job: N=3, A=1,2,3, B=10,20,30, behavioural accelerator model attached, m_ready=1 -> exactly 8 consecutive pushes; downstream receives 11,22,33; o_busy falls after the last transfer.
- Signed wrap: N=2, A=0x7FFF,0xFFFF, B=0x0001,0xFFFF -> outputs 0x8000,0xFFFE.
- Back-pressure: N=4, i_m_ready toggles 1 cycle high / 3 cycles low -> no result is lost or duplicated; o_dev_pop is never asserted while FIFO occupancy plus pops in flight is 2.
- Upstream gaps: N=3 words delivered with random valid gaps -> push burst remains 8 cycles without a hole.
- Bad count: N=0, then N=MAX_ELEMS+1 -> o_err pulses twice and no push occurs; a following valid N=1 job (5+7) outputs 12.
- Reset mid-burst: assert i_rst_n=0 at burst cycle 3 -> all outputs 0 in the same cycle; after release, FSM is in IDLE and o_s_ready=1 on the first clock.
